mc_datapath: RTL and testbench

Multi-cycle, parametrised successor to the single-cycle register-file/ALU/data-memory datapath. Accepts one pre-decoded micro-op per valid/ready handshake, sequences it through execute, optional memory and write-back states, and pulses `done` on retirement. Adds reset, hard-wired x0, a configurable-latency data memory and a full 8-op ALU. Sits below the control/decode unit, which issues micro-ops and waits for `done`.

---
 rtl/mc_datapath_pkg.sv | 25 ++
 rtl/mc_regfile.sv | 40 ++++
 rtl/mc_datapath.sv | 175 +++++++++++++++++
 tb/tb_mc_datapath.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_datapath_pkg.sv
// Shared types and constants for the multi-cycle datapath: ALU encodings,
// sequencer states and the architectural index of register a0.
package mc_datapath_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_MEM  = 2'b10,
        ST_WB   = 2'b11
    } state_e;

    localparam int unsigned A0_IDX = 10;

endpackage

// File: rtl/mc_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// x0 hard-wired to zero, live tap of register a0.
module mc_regfile
    import mc_datapath_pkg::*;
#(
    parameter int A_WIDTH = 5,
    parameter int D_WIDTH = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [A_WIDTH-1:0] ra1_i,
    input  logic [A_WIDTH-1:0] ra2_i,
    output logic [D_WIDTH-1:0] rd1_o,
    output logic [D_WIDTH-1:0] rd2_o,
    input  logic               we_i,
    input  logic [A_WIDTH-1:0] wa_i,
    input  logic [D_WIDTH-1:0] wd_i,
    output logic [D_WIDTH-1:0] a0_o
);

    localparam int NREGS = 2 ** A_WIDTH;
    localparam logic [A_WIDTH-1:0] A0_ADDR = A_WIDTH'(A0_IDX);

    logic [D_WIDTH-1:0] regs_q [NREGS];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == '0) ? '0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == '0) ? '0 : regs_q[ra2_i];
    assign a0_o  = regs_q[A0_ADDR];

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle datapath: IDLE -> EXEC -> [MEM] -> WB, one micro-op per handshake.
// Optional misaligned-access trap enabled by defining MC_DATAPATH_ALIGN_CHECK_EN.
module mc_datapath
    import mc_datapath_pkg::*;
#(
    parameter int A_WIDTH     = 5,
    parameter int D_WIDTH     = 32,
    parameter int MEM_A_WIDTH = 10,
    parameter int MEM_LAT     = 2
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic               ALUSrc,
    input  logic [2:0]         ALUControl,
    input  logic               RegWrite,
    input  logic [A_WIDTH-1:0] A1,
    input  logic [A_WIDTH-1:0] A2,
    input  logic [A_WIDTH-1:0] A3,
    input  logic [D_WIDTH-1:0] ImmExt,
    input  logic               ResultSrc,
    input  logic               MemWrite,
    output logic               done,
    output logic               Zero,
    output logic               err,
    output logic [D_WIDTH-1:0] a0
);

    localparam int SH_W  = $clog2(D_WIDTH);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
    localparam int MEM_DEPTH = 2 ** MEM_A_WIDTH;

    // Handshake: a micro-op transfers on a cycle where op_valid && op_ready;
    // op_ready is only high in IDLE outside reset, and the source holds
    // op_valid and the fields until that transfer happens.
    state_e state_q, state_d;

    logic               alu_src_q, reg_write_q, result_src_q, mem_write_q;
    alu_op_e            alu_ctrl_q;
    logic [A_WIDTH-1:0] a1_q, a2_q, a3_q;
    logic [D_WIDTH-1:0] imm_q;
    logic [D_WIDTH-1:0] alu_res_q, rd2_q, load_q;
    logic               zero_q, misalign_q, misalign_d;
    logic [CNT_W-1:0]   cnt_q;

    logic [D_WIDTH-1:0] rd1, rd2, src_b, alu_res, wb_data, mem_rdata;
    logic [SH_W-1:0]    shamt;
    logic [MEM_A_WIDTH-1:0] mem_addr;
    logic               accept, mem_op, reg_we;

    logic [D_WIDTH-1:0] mem_q [MEM_DEPTH];

    assign accept   = op_valid && op_ready;
    assign op_ready = (state_q == ST_IDLE) && !RST;
    assign done     = (state_q == ST_WB);
    assign Zero     = zero_q;
    assign mem_op   = result_src_q || mem_write_q;

    mc_regfile #(
        .A_WIDTH (A_WIDTH),
        .D_WIDTH (D_WIDTH)
    ) u_regfile (
        .clk_i (CLK),
        .rst_i (RST),
        .ra1_i (a1_q),
        .ra2_i (a2_q),
        .rd1_o (rd1),
        .rd2_o (rd2),
        .we_i  (reg_we),
        .wa_i  (a3_q),
        .wd_i  (wb_data),
        .a0_o  (a0)
    );

    always_comb begin
        src_b   = alu_src_q ? imm_q : rd2;
        shamt   = src_b[SH_W-1:0];
        alu_res = '0;
        case (alu_ctrl_q)
            ALU_ADD: alu_res = rd1 + src_b;
            ALU_SUB: alu_res = rd1 - src_b;
            ALU_AND: alu_res = rd1 & src_b;
            ALU_OR:  alu_res = rd1 | src_b;
            ALU_XOR: alu_res = rd1 ^ src_b;
            ALU_SLT: alu_res[0] = ($signed(rd1) < $signed(src_b));
            ALU_SLL: alu_res = rd1 << shamt;
            ALU_SRL: alu_res = rd1 >> shamt;
            default: alu_res = '0;
        endcase
    end

`ifdef MC_DATAPATH_ALIGN_CHECK_EN
    assign misalign_d = mem_op && (alu_res[1:0] != 2'b00);
    assign err        = (state_q == ST_WB) && misalign_q;
`else
    assign misalign_d = 1'b0;
    assign err        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = (mem_op && !misalign_d) ? ST_MEM : ST_WB;
            ST_MEM:  if (mem_write_q || (cnt_q == '0)) state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            alu_src_q    <= 1'b0;
            alu_ctrl_q   <= ALU_ADD;
            reg_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            mem_write_q  <= 1'b0;
            a1_q         <= '0;
            a2_q         <= '0;
            a3_q         <= '0;
            imm_q        <= '0;
            alu_res_q    <= '0;
            rd2_q        <= '0;
            load_q       <= '0;
            zero_q       <= 1'b0;
            misalign_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_src_q    <= ALUSrc;
                alu_ctrl_q   <= alu_op_e'(ALUControl);
                reg_write_q  <= RegWrite;
                result_src_q <= ResultSrc;
                mem_write_q  <= MemWrite;
                a1_q         <= A1;
                a2_q         <= A2;
                a3_q         <= A3;
                imm_q        <= ImmExt;
            end
            if (state_q == ST_EXEC) begin
                alu_res_q  <= alu_res;
                rd2_q      <= rd2;
                zero_q     <= (alu_res == '0);
                misalign_q <= misalign_d;
                cnt_q      <= CNT_INIT;
            end
            // Load wait: data is sampled once the latency counter has drained.
            if ((state_q == ST_MEM) && !mem_write_q) begin
                if (cnt_q == '0) begin
                    load_q <= mem_rdata;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    assign mem_addr  = alu_res_q[MEM_A_WIDTH+1:2];
    assign mem_rdata = mem_q[mem_addr];

    // Data memory is deliberately not reset; contents survive RST.
    always_ff @(posedge CLK) begin
        if ((state_q == ST_MEM) && mem_write_q) begin
            mem_q[mem_addr] <= rd2_q;
        end
    end

    assign wb_data = (result_src_q && !mem_write_q) ? load_q : alu_res_q;
    assign reg_we  = (state_q == ST_WB) && reg_write_q && !misalign_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench for mc_datapath: the driver pushes expected retirement records,
// an independent monitor checks them when done pulses.
module tb_mc_datapath;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int EW = DW + 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          op_valid, op_ready;
  logic          alu_src, reg_write, result_src, mem_write;
  logic [2:0]    alu_ctrl;
  logic [AW-1:0] a1, a2, a3;
  logic [DW-1:0] imm;
  logic          done, zero, err;
  logic [DW-1:0] a0;

  logic [EW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int issued  = 0;
  int accepts = 0;

  mc_datapath dut (
    .CLK        (clk),
    .RST        (rst),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .ALUSrc     (alu_src),
    .ALUControl (alu_ctrl),
    .RegWrite   (reg_write),
    .A1         (a1),
    .A2         (a2),
    .A3         (a3),
    .ImmExt     (imm),
    .ResultSrc  (result_src),
    .MemWrite   (mem_write),
    .done       (done),
    .Zero       (zero),
    .err        (err),
    .a0         (a0)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver
  task automatic send(input bit hold, input bit src, input logic [2:0] ctrl,
                      input bit rw, input int ra1, input int ra2, input int ra3,
                      input logic [DW-1:0] im, input bit rsrc, input bit mw,
                      input logic [DW-1:0] exp_a0, input bit exp_zero,
                      input bit exp_err, input int exp_lat);
    bit got;
    got        = 1'b0;
    alu_src    = src;
    alu_ctrl   = ctrl;
    reg_write  = rw;
    a1         = AW'(ra1);
    a2         = AW'(ra2);
    a3         = AW'(ra3);
    imm        = im;
    result_src = rsrc;
    mem_write  = mw;
    op_valid   = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (op_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      exp_q.push_back({exp_a0, exp_zero, exp_err, 8'(exp_lat)});
      issued++;
    end else begin
      check("accept_timeout", 64'd0, 64'd1);
    end
    @(posedge clk);
    #1;
    if (!hold) op_valid = 1'b0;
  endtask

  // scoreboard monitor
  int            cyc = 0;
  int            acc_cyc = 0;
  bit            busy = 1'b0;
  bit            ready_bad = 1'b0;
  bit            a0_pend = 1'b0;
  logic [DW-1:0] a0_exp;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst) begin
      busy    = 1'b0;
      a0_pend = 1'b0;
    end else begin
      if (a0_pend) begin
        check("a0_after_wb", 64'(a0), 64'(a0_exp));
        a0_pend = 1'b0;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("zero", 64'(zero), 64'(e[9]));
          check("err", 64'(err), 64'(e[8]));
          check("latency", 64'(cyc - acc_cyc), 64'(e[7:0]));
          check("ready_low_while_busy", 64'(ready_bad), 64'd0);
          a0_exp  = e[EW-1:10];
          a0_pend = 1'b1;
        end
        busy = 1'b0;
      end else if (busy && op_ready) begin
        ready_bad = 1'b1;
      end
      if (op_valid && op_ready) begin
        busy      = 1'b1;
        ready_bad = 1'b0;
        acc_cyc   = cyc;
        accepts++;
      end
    end
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    op_valid = 1'b0;
    alu_src = 1'b0; alu_ctrl = 3'b000; reg_write = 1'b0;
    a1 = '0; a2 = '0; a3 = '0; imm = '0;
    result_src = 1'b0; mem_write = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_op_ready", 64'(op_ready), 64'd1);
    check("reset_done", 64'(done), 64'd0);
    check("reset_zero", 64'(zero), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    check("reset_a0", 64'(a0), 64'd0);
    @(posedge clk);
    #1;

    //   hold src ctrl rw a1 a2 a3  imm           rs mw  a0           z  e  lat
    send(0, 1, 3'b000, 1, 0, 0, 10, 32'd5,        0, 0, 32'd5,        0, 0, 2);
    send(0, 1, 3'b000, 0, 0, 10, 0, 32'd8,        0, 1, 32'd5,        0, 0, 3);
    send(0, 1, 3'b000, 1, 0, 0, 11, 32'd8,        1, 0, 32'd5,        0, 0, 4);
    send(0, 0, 3'b001, 1, 11, 10, 12, 32'd0,      0, 0, 32'd5,        1, 0, 2);
    send(0, 1, 3'b000, 1, 0, 0, 0,  32'd7,        0, 0, 32'd5,        0, 0, 2);
    send(0, 1, 3'b000, 1, 0, 0, 10, 32'd0,        0, 0, 32'd0,        1, 0, 2);
    send(0, 1, 3'b000, 1, 0, 0, 13, 32'hFFFFFFFF, 0, 0, 32'd0,        0, 0, 2);
    send(0, 1, 3'b101, 1, 13, 0, 10, 32'd1,       0, 0, 32'd1,        0, 0, 2);
    send(0, 1, 3'b000, 1, 0, 0, 14, 32'h80000000, 0, 0, 32'd1,        0, 0, 2);
    send(0, 1, 3'b111, 1, 14, 0, 10, 32'd31,      0, 0, 32'd1,        0, 0, 2);
    send(0, 1, 3'b111, 1, 14, 0, 10, 32'd28,      0, 0, 32'd8,        0, 0, 2);
    send(0, 1, 3'b000, 1, 0, 0, 15, 32'h0000F0F0, 0, 0, 32'd8,        0, 0, 2);
    send(0, 1, 3'b010, 1, 15, 0, 10, 32'h00000FF0, 0, 0, 32'h000000F0, 0, 0, 2);
    send(0, 1, 3'b011, 1, 15, 0, 10, 32'h0000000F, 0, 0, 32'h0000F0FF, 0, 0, 2);
    send(0, 1, 3'b100, 1, 15, 0, 10, 32'h0000FFFF, 0, 0, 32'h00000F0F, 0, 0, 2);
    send(0, 1, 3'b110, 1, 15, 0, 10, 32'd4,       0, 0, 32'h000F0F00, 0, 0, 2);
    send(0, 1, 3'b001, 1, 0, 0, 10, 32'd1,        0, 0, 32'hFFFFFFFF, 0, 0, 2);
    send(0, 1, 3'b000, 1, 10, 0, 10, 32'd1,       0, 0, 32'd0,        1, 0, 2);

    // load into x10 abandoned by reset in its first MEM cycle
    send(0, 1, 3'b000, 1, 0, 0, 10, 32'd8,        1, 0, 32'd5,        0, 0, 4);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_op_ready", 64'(op_ready), 64'd1);
    check("post_rst_a0", 64'(a0), 64'd0);
    check("post_rst_zero", 64'(zero), 64'd0);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    send(0, 0, 3'b001, 1, 11, 0, 12, 32'd0,       0, 0, 32'd0,        1, 0, 2);
    send(0, 1, 3'b000, 1, 0, 0, 10, 32'd8,        1, 0, 32'd5,        0, 0, 4);

    // op_valid held high across three chained ops
    send(1, 1, 3'b000, 1, 0, 0, 10, 32'd1,        0, 0, 32'd1,        0, 0, 2);
    send(1, 1, 3'b000, 1, 10, 0, 10, 32'd2,       0, 0, 32'd3,        0, 0, 2);
    send(0, 1, 3'b000, 1, 10, 0, 10, 32'd3,       0, 0, 32'd6,        0, 0, 2);

    // store and load both set: store wins, Result = ALUResult
    send(0, 1, 3'b000, 1, 0, 10, 10, 32'd12,      1, 1, 32'd12,       0, 0, 3);
    send(0, 1, 3'b000, 1, 0, 0, 10, 32'd12,       1, 0, 32'd6,        0, 0, 4);
    send(0, 1, 3'b000, 0, 0, 10, 0, 32'd4,        0, 1, 32'd6,        0, 0, 3);
    send(0, 1, 3'b000, 1, 0, 0, 10, 32'd9,        0, 0, 32'd9,        0, 0, 2);
`ifdef MC_DATAPATH_ALIGN_CHECK_EN
    send(0, 1, 3'b000, 1, 0, 0, 10, 32'd6,        1, 0, 32'd9,        0, 1, 2);
`else
    send(0, 1, 3'b000, 1, 0, 0, 10, 32'd6,        1, 0, 32'd6,        0, 0, 4);
`endif

    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("accepted_once_each", 64'(accepts), 64'(issued));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
